// File: rtl/stream_filter3x3.sv
// Streaming 3x3 image filter (pass / smooth / sharpen / enhance) with zero padding.
// The two line buffers and the window are one history of the last 2*IMG_W+2 pixels.
module stream_filter3x3 #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 128,
    parameter int unsigned IMG_H  = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eol,
    output logic              frame_done,
    output logic              busy
);
    localparam int unsigned NPIX  = IMG_W * IMG_H;
    localparam int unsigned CNT_W = $clog2(NPIX + 1);
    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned SUM_W = DATA_W + 5;
    localparam int unsigned DEPTH = 2 * IMG_W + 2;
    localparam logic signed [SUM_W-1:0] MAXV = SUM_W'((1 << DATA_W) - 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    in_cnt, prod_cnt;
    logic [COL_W-1:0]    pc;
    logic [ROW_W-1:0]    pr;
    logic [1:0]          mode_q;
    logic                out_last;
    logic [DATA_W-1:0]   hist [DEPTH];
    logic                stage_free, accept, produce, shift, done;
    logic [DATA_W-1:0]   newest, result;
    logic                has_t, has_b, has_l, has_r;
    logic signed [SUM_W-1:0] w_tl, w_tm, w_tr, w_ml, ctr, w_mr, w_bl, w_bm, w_br;
    logic signed [SUM_W-1:0] n4, s8, lap, enh;
    logic [SUM_W-1:0]    sum9;

    function automatic logic signed [SUM_W-1:0] tap(input logic [DATA_W-1:0] v, input logic en);
        return en ? SUM_W'(v) : '0;
    endfunction

    function automatic logic [DATA_W-1:0] clamp(input logic signed [SUM_W-1:0] v);
        if (v[SUM_W-1]) return '0;
        if (v > MAXV) return DATA_W'(MAXV);
        return DATA_W'(v);
    endfunction

    assign stage_free = !out_valid || out_ready;
    assign in_ready   = (state_q != FLUSH) && stage_free;
    assign accept     = in_valid && in_ready;
    assign done       = (state_q == FLUSH) && out_valid && out_ready && out_last;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Output k is produced by the accept of input k+IMG_W+1; the tail drains in FLUSH.
    always_comb begin
        state_d = state_q;
        produce = 1'b0;
        case (state_q)
            IDLE: if (accept) state_d = FILL;
            FILL, RUN: begin
                produce = accept && (in_cnt >= CNT_W'(IMG_W + 1));
                if (accept && (in_cnt == CNT_W'(NPIX - 1))) state_d = FLUSH;
                else if (produce)                           state_d = RUN;
            end
            FLUSH: begin
                produce = stage_free && (prod_cnt != CNT_W'(NPIX));
                if (done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Zeros are shifted in during FLUSH so the tap offsets stay fixed.
    assign shift  = accept || ((state_q == FLUSH) && produce);
    assign newest = accept ? in_data : '0;

    always_ff @(posedge clk) begin
        if (shift) begin
            hist[0] <= newest;
            for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
        end
    end

    always_comb begin
        has_t = (pr != '0);
        has_b = (pr != ROW_W'(IMG_H - 1));
        has_l = (pc != '0);
        has_r = (pc != COL_W'(IMG_W - 1));
        w_tl  = tap(hist[2*IMG_W+1], has_t && has_l);
        w_tm  = tap(hist[2*IMG_W],   has_t);
        w_tr  = tap(hist[2*IMG_W-1], has_t && has_r);
        w_ml  = tap(hist[IMG_W+1],   has_l);
        ctr   = tap(hist[IMG_W],     1'b1);
        w_mr  = tap(hist[IMG_W-1],   has_r);
        w_bl  = tap(hist[1],         has_b && has_l);
        w_bm  = tap(hist[0],         has_b);
        w_br  = tap(newest,          has_b && has_r);
        n4    = w_tm + w_ml + w_mr + w_bm;
        s8    = n4 + w_tl + w_tr + w_bl + w_br;
        sum9  = $unsigned(ctr + s8);
        lap   = (ctr <<< 2) - n4;
        enh   = ctr + lap;
        case (mode_q)
            2'd0:    result = hist[IMG_W];
            2'd1:    result = DATA_W'(sum9 / SUM_W'(9));
            2'd2:    result = clamp(lap);
            default: result = clamp(enh);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_cnt     <= '0;
            prod_cnt   <= '0;
            pc         <= '0;
            pr         <= '0;
            mode_q     <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_eol    <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (accept) begin
                in_cnt <= in_cnt + CNT_W'(1);
                if (state_q == IDLE) begin
                    mode_q <= mode;
                    busy   <= 1'b1;
                end
            end
            if (produce) begin
                out_data  <= result;
                out_valid <= 1'b1;
                out_sof   <= (prod_cnt == '0);
                out_eol   <= (pc == COL_W'(IMG_W - 1));
                out_last  <= (prod_cnt == CNT_W'(NPIX - 1));
                prod_cnt  <= prod_cnt + CNT_W'(1);
                if (pc == COL_W'(IMG_W - 1)) begin
                    pc <= '0;
                    pr <= pr + ROW_W'(1);
                end else begin
                    pc <= pc + COL_W'(1);
                end
            end
            if (done) begin
                frame_done <= 1'b1;
                busy       <= 1'b0;
                in_cnt     <= '0;
                prod_cnt   <= '0;
                pc         <= '0;
                pr         <= '0;
            end
        end
    end
endmodule

// File: tb/tb_stream_filter3x3.sv
// Scoreboard bench for stream_filter3x3: a 4x3 instance for directed frames, a 128x128 one for stress.
module tb_stream_filter3x3;
    localparam int SW = 4, SH = 3, BW = 128, BH = 128;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eol;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       sel = 1'b0;

    logic       s_in_ready, s_out_valid, s_out_sof, s_out_eol, s_frame_done, s_busy;
    logic [7:0] s_out_data;
    logic       b_in_ready, b_out_valid, b_out_sof, b_out_eol, b_frame_done, b_busy;
    logic [7:0] b_out_data;
    logic       m_in_ready, m_valid, m_sof, m_eol, m_done, m_busy;
    logic [7:0] m_data;

    int   n_cmp = 0, n_err = 0;
    exp_t exp_q[$];
    int   frame_pix[];
    int   done_cnt, acc_cnt, flush_prod, cur_w, ready_pct = 100;
    bit   first_pending = 0, ignore_out = 0, hold_pending = 0;
    bit   prev_valid = 0, prev_hs = 0, prev_in_ready = 1;
    logic [9:0] held;

    always #5 clk = ~clk;

    stream_filter3x3 #(.DATA_W(8), .IMG_W(SW), .IMG_H(SH)) u_small (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_data(in_data),
        .in_valid(in_valid && !sel), .in_ready(s_in_ready),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(out_ready && !sel),
        .out_sof(s_out_sof), .out_eol(s_out_eol), .frame_done(s_frame_done), .busy(s_busy)
    );

    stream_filter3x3 #(.DATA_W(8), .IMG_W(BW), .IMG_H(BH)) u_big (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_data(in_data),
        .in_valid(in_valid && sel), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(out_ready && sel),
        .out_sof(b_out_sof), .out_eol(b_out_eol), .frame_done(b_frame_done), .busy(b_busy)
    );

    assign m_in_ready = sel ? b_in_ready   : s_in_ready;
    assign m_valid    = sel ? b_out_valid  : s_out_valid;
    assign m_data     = sel ? b_out_data   : s_out_data;
    assign m_sof      = sel ? b_out_sof    : s_out_sof;
    assign m_eol      = sel ? b_out_eol    : s_out_eol;
    assign m_done     = sel ? b_frame_done : s_frame_done;
    assign m_busy     = sel ? b_busy       : s_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int px(input int r, input int c, input int w, input int h);
        if (r < 0 || r >= h || c < 0 || c >= w) return 0;
        return frame_pix[r*w + c];
    endfunction

    function automatic int clamp255(input int v);
        return (v < 0) ? 0 : (v > 255) ? 255 : v;
    endfunction

    function automatic int model(input int md, input int r, input int c, input int w, input int h);
        int cv, s8, n4, v;
        cv = px(r, c, w, h);
        s8 = 0;
        n4 = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (dr != 0 || dc != 0) begin
                    v = px(r + dr, c + dc, w, h);
                    s8 += v;
                    if (dr == 0 || dc == 0) n4 += v;
                end
        case (md)
            0:       return cv;
            1:       return (cv + s8) / 9;
            2:       return clamp255(4*cv - n4);
            default: return clamp255(5*cv - n4);
        endcase
    endfunction

    // Randomised downstream back-pressure.
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(99) < ready_pct);
    end

    // Output monitor: scoreboard pop, hold stability, latency and flush accounting.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            hold_pending  = 0;
            prev_valid    = 0;
            prev_hs       = 0;
            prev_in_ready = 1;
        end else begin
            if (m_done) done_cnt++;
            if (hold_pending)
                check("hold_stable", 32'({m_valid, m_sof, m_eol, m_data}), 32'({1'b1, held}));
            if (m_valid && (!prev_valid || prev_hs) && !ignore_out) begin
                if (!prev_in_ready) flush_prod++;
                if (first_pending) begin
                    check("first_latency", 32'(acc_cnt), 32'(cur_w + 2));
                    first_pending = 0;
                end
            end
            hold_pending = m_valid && !out_ready;
            held = {m_sof, m_eol, m_data};
            if (m_valid && out_ready && !ignore_out) begin
                if (exp_q.size() == 0) begin
                    check("extra_output", 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("data", 32'(m_data), 32'(e.data));
                    check("sof", 32'(m_sof), 32'(e.sof));
                    check("eol", 32'(m_eol), 32'(e.eol));
                end
            end
            prev_valid    = m_valid;
            prev_hs       = m_valid && out_ready;
            prev_in_ready = m_in_ready;
        end
    end

    task automatic send(input logic [7:0] v, input int stall);
        bit sent;
        int guard;
        sent  = 0;
        guard = 0;
        while (!sent) begin
            in_valid = ($urandom_range(99) >= stall);
            in_data  = v;
            @(negedge clk);
            sent = in_valid && m_in_ready;
            @(posedge clk);
            #1;
            guard++;
            if (!sent && guard > 2000) begin
                check("input_timeout", 32'(0), 32'(1));
                $fatal(1, "input never accepted");
            end
        end
        in_valid = 1'b0;
        acc_cnt++;
    endtask

    // kind: 0 constant 90, 1 ramp, 2 random.
    task automatic run_frame(input bit s, input int md, input int md_mid, input int kind,
                             input int in_stall, input int rdy);
        int w, h, n, guard;
        exp_t e;
        w = s ? BW : SW;
        h = s ? BH : SH;
        n = w * h;
        sel = s;
        ready_pct = rdy;
        frame_pix = new[n];
        for (int i = 0; i < n; i++)
            frame_pix[i] = (kind == 0) ? 90 : (kind == 1) ? (i % 256) : int'($urandom_range(255));
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                e.data = 8'(model(md, r, c, w, h));
                e.sof  = (r == 0 && c == 0);
                e.eol  = (c == w - 1);
                exp_q.push_back(e);
            end
        done_cnt = 0;
        acc_cnt = 0;
        flush_prod = 0;
        cur_w = w;
        first_pending = 1;
        mode = 2'(md);
        for (int i = 0; i < n; i++) begin
            if (i == n / 2) mode = 2'(md_mid);
            send(8'(frame_pix[i]), in_stall);
            if (i == 0) check("busy_after_first", 32'(m_busy), 32'(1));
        end
        guard = 0;
        while (done_cnt == 0 && guard < 60000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("frame_done_seen", 32'(done_cnt != 0), 32'(1));
        repeat (3) @(posedge clk);
        #1;
        check("frame_done_pulses", 32'(done_cnt), 32'(1));
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        check("flush_outputs", 32'(flush_prod), 32'(w + 1));
        check("busy_after_done", 32'(m_busy), 32'(0));
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_out_valid", 32'(m_valid), 32'(0));
        check("rst_out_data", 32'(m_data), 32'(0));
        check("rst_out_sof", 32'(m_sof), 32'(0));
        check("rst_out_eol", 32'(m_eol), 32'(0));
        check("rst_frame_done", 32'(m_done), 32'(0));
        check("rst_busy", 32'(m_busy), 32'(0));
        check("rst_in_ready", 32'(m_in_ready), 32'(1));

        run_frame(0, 1, 1, 0, 0, 100);
        run_frame(0, 2, 2, 0, 0, 100);
        run_frame(0, 3, 3, 0, 0, 100);
        run_frame(0, 0, 0, 1, 0, 100);
        run_frame(0, 1, 2, 2, 0, 100);
        run_frame(0, 2, 2, 2, 0, 100);
        run_frame(0, 3, 3, 2, 30, 60);

        // Abandon a frame with reset while input 7 is offered.
        sel = 0;
        ignore_out = 1;
        ready_pct = 100;
        mode = 2'd1;
        acc_cnt = 0;
        for (int i = 0; i < 7; i++) send(8'(i * 10), 0);
        in_valid = 1'b1;
        in_data = 8'd70;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        check("abort_out_valid", 32'(m_valid), 32'(0));
        check("abort_busy", 32'(m_busy), 32'(0));
        ignore_out = 0;
        run_frame(0, 3, 3, 2, 0, 100);

        run_frame(1, 3, 3, 2, 20, 75);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/stream_filter3x3.md
Name: stream_filter3x3

Overview:
- Streaming, parametrised successor to the frame-buffered image enhancer.
- Accepts one raster-order pixel per handshake and keeps two line buffers plus a 3x3 window instead of whole-frame matrices.
- Emits one filtered pixel per handshake: smoothed, Laplacian-sharpened, enhanced, or passed through, selected per frame.
- Sits between the pixel source and the downstream writer, with valid/ready flow control on both sides.

Parameters:
- DATA_W, 8: pixel width in bits; MAXV = 2^DATA_W-1.
- IMG_W, 128: pixels per row; must be >= 2.
- IMG_H, 128: rows per frame; must be >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- mode  input  2  filter select, sampled on the first accepted pixel of a frame: 0 pass, 1 smooth, 2 sharpen, 3 enhance.
- in_data  input  DATA_W  input pixel, raster order, row-major.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts in_data this cycle.
- out_data  output  DATA_W  filtered pixel.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- out_sof  output  1  qualifies out_data as pixel (0,0).
- out_eol  output  1  qualifies out_data as last pixel of a row.
- frame_done  output  1  one-cycle pulse after the last output handshake of a frame.
- busy  output  1  high from the first accepted pixel until frame_done.

Behaviour:
- Reset, rst_n=0 at a clk edge: state=IDLE; input/output counters=0; out_valid, out_sof, out_eol, frame_done, busy = 0; out_data=0. Line-buffer contents are not cleared and are don't-care. Reset mid-frame abandons the frame, and the next accepted pixel is (0,0).
- Pixel index k = r*IMG_W + c; N = IMG_W*IMG_H.
- Window: P(r,c) with neighbours in rows r±1 and cols c±1. Any neighbour outside the frame reads as 0 (zero padding), decided by counter position, never by buffer contents.
- Schedule: output k is produced on the edge that accepts input k+IMG_W+1, for k < N-IMG_W-1. The remaining IMG_W+1 outputs are produced in FLUSH, one per cycle the output stage is free.
- States:
  - IDLE: in_ready=1. First accept latches mode, busy=1, state goes to FILL.
  - FILL: accept inputs 1..IMG_W with no output. The accept of input IMG_W+1 produces output 0 and moves to RUN.
  - RUN: each accept produces one output. After accepting input N-1, go to FLUSH.
  - FLUSH: in_ready=0. Produce the remaining outputs. After the last output handshake, pulse frame_done, clear busy, go to IDLE.
- Flow control: output register is 1 deep. in_ready = (state != FLUSH) && (!out_valid || out_ready). out_valid holds, with out_data/out_sof/out_eol stable, until out_ready=1. A simultaneous output handshake and new production in the same edge is legal: the register reloads and out_valid stays 1.
- Arithmetic: C = centre; S8 = sum of the 8 neighbours; N4 = sum of the 4 orthogonal neighbours. Internal width is DATA_W+5, signed.
  - mode 0: C.
  - mode 1: floor((C+S8)/9). Exact divide; no approximation.
  - mode 2: L = 4C - N4, clamped to [0, MAXV].
  - mode 3: C + L using unclamped L, then clamped to [0, MAXV].
- out_sof=1 only for k=0; out_eol=1 when c=IMG_W-1.
- A mode change mid-frame has no effect until the next frame.
- in_valid=0 stalls the schedule; no bubbles are inserted in the output order.

Test Plan:
- Reset, then a 4x3 frame of constant 90 with out_ready=1 and mode=1 -> 12 outputs: corners 40, edges 60, the two interior pixels 90. out_sof on the first output, out_eol on outputs 3, 7, 11, then frame_done pulses once.
- Same frame, mode=2 -> corners 180, edges 90, interior 0. mode=3 -> corners 255 (270 clamped), edges 180, interior 90.
- 4x3 ramp 0..11, mode=0 -> outputs 0..11 in order. The first out_valid occurs only after input 5 is accepted; the last 5 outputs appear in FLUSH while in_ready=0.
- Random out_ready/in_valid toggling on a 128x128 frame, mode=3 -> output matches the golden model bit-exact, out_data is stable while stalled, and no pixel is dropped or duplicated.
- rst_n=0 asserted at input index 7 of a frame, then a fresh full frame -> no outputs from the aborted frame after reset; the new frame is correct, with out_sof on its first output.
- mode switched 1->2 mid-frame -> the whole frame is smoothed; the next frame is sharpened.
